// File: rtl/rvv_lane_sequencer.sv
// Element/lane sequencer for the RVV arithmetic path: walks the elements of one
// vector instruction in NB_LANES-wide beats, slicing wide elements into lane-width sub-beats.
module rvv_lane_sequencer #(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 3,
  parameter int NB_LANES   = 4,
  parameter int IDX_W      = 17
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [16:0]                  vl,
  input  logic [2:0]                   vsew,
  input  logic                         instr_mask,
  output logic                         busy,
  output logic                         beat_valid,
  input  logic                         beat_ready,
  output logic [IDX_W-1:0]             elem_base,
  output logic [NB_LANES-1:0]          lane_en,
  output logic [IDX_W*NB_LANES-1:0]    lane_idx,
  output logic [3:0]                   sub_beat,
  output logic                         last_beat,
  output logic                         done,
  output logic                         err_illegal,
  output logic [1:0]                   dbg_state
);

  // Handshake: a beat transfers on a rising edge where beat_valid && beat_ready;
  // while beat_valid is high and beat_ready low, every beat output holds stable.

  localparam int CW = IDX_W + 1;
  localparam int LW = 1 << LANE_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] base_q, base_d;
  logic [3:0]       sub_q, sub_d;
  logic [CW-1:0]    n_q, n_d;
  logic [3:0]       subb_last_q, subb_last_d;
  logic             err_q, err_d;

  logic [31:0]      sew_w;
  logic [31:0]      ratio_w;
  logic             sew_ok;
  logic [CW-1:0]    emax_w;
  logic [CW-1:0]    vl_w;
  logic [CW-1:0]    n_w;
  logic [3:0]       subb_last_w;
  logic             run;
  logic             xfer;
  logic             last_w;

  // Instruction decode, only meaningful in the cycle start is accepted.
  always_comb begin
    sew_w       = 32'd8 << vsew;
    ratio_w     = sew_w >> LANE_WIDTH;
    sew_ok      = (vsew <= 3'd3) && (ratio_w <= 32'd16);
    emax_w      = CW'(VLEN >> (32'(vsew) + 32'd3));
    vl_w        = CW'(vl);
    n_w         = instr_mask ? emax_w : ((vl_w < emax_w) ? vl_w : emax_w);
    subb_last_w = (sew_w <= 32'(LW)) ? 4'd0 : 4'(ratio_w - 32'd1);
  end

  assign run    = (state_q == S_RUN);
  assign xfer   = run && beat_ready;
  assign last_w = (({1'b0, base_q} + CW'(NB_LANES)) >= n_q) && (sub_q == subb_last_q);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    sub_d       = sub_q;
    n_d         = n_q;
    subb_last_d = subb_last_q;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (!sew_ok) begin
            err_d = 1'b1;
          end else begin
            base_d      = '0;
            sub_d       = '0;
            n_d         = n_w;
            subb_last_d = subb_last_w;
            state_d     = (n_w == '0) ? S_DONE : S_RUN;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (xfer) begin
          if (last_w) state_d = S_DONE;
          if (sub_q == subb_last_q) begin
            sub_d  = '0;
            base_d = base_q + IDX_W'(NB_LANES);
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      sub_q       <= '0;
      n_q         <= '0;
      subb_last_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      sub_q       <= sub_d;
      n_q         <= n_d;
      subb_last_q <= subb_last_d;
      err_q       <= err_d;
    end
  end

  // Beat outputs are forced to zero outside RUN so idle lanes never see stale indices.
  for (genvar i = 0; i < NB_LANES; i++) begin : g_lane
    logic [CW-1:0] lane_sum;
    assign lane_sum = {1'b0, base_q} + CW'(i);
    assign lane_en[i] = run && (lane_sum < n_q);
    assign lane_idx[i*IDX_W +: IDX_W] = run ? (base_q + IDX_W'(i)) : '0;
  end

  assign busy        = (state_q != S_IDLE);
  assign beat_valid  = run;
  assign elem_base   = run ? base_q : '0;
  assign sub_beat    = run ? sub_q : '0;
  assign last_beat   = run && last_w;
  assign done        = (state_q == S_DONE) && !abort;
  assign err_illegal = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_rvv_lane_sequencer.sv
// Directed bench for rvv_lane_sequencer: expected beats are queued by hand and
// checked at the falling edge while the DUT works on the rising edge.
module tb_rvv_lane_sequencer;

  localparam int VLEN       = 128;
  localparam int LANE_WIDTH = 3;
  localparam int NB         = 4;
  localparam int IDX_W      = 17;
  localparam int BW         = 1 + NB + 4 + IDX_W;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic                  abort;
  logic [16:0]           vl;
  logic [2:0]            vsew;
  logic                  instr_mask;
  logic                  busy;
  logic                  beat_valid;
  logic                  beat_ready;
  logic [IDX_W-1:0]      elem_base;
  logic [NB-1:0]         lane_en;
  logic [IDX_W*NB-1:0]   lane_idx;
  logic [3:0]            sub_beat;
  logic                  last_beat;
  logic                  done;
  logic                  err_illegal;
  logic [1:0]            dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  // Each entry: {last_beat, lane_en, sub_beat, elem_base}
  logic [BW-1:0] exp_q[$];

  rvv_lane_sequencer #(
    .VLEN(VLEN), .LANE_WIDTH(LANE_WIDTH), .NB_LANES(NB), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .vl(vl), .vsew(vsew),
    .instr_mask(instr_mask), .busy(busy), .beat_valid(beat_valid), .beat_ready(beat_ready),
    .elem_base(elem_base), .lane_en(lane_en), .lane_idx(lane_idx), .sub_beat(sub_beat),
    .last_beat(last_beat), .done(done), .err_illegal(err_illegal), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input int elem, input int sub, input logic [NB-1:0] en, input logic last);
    exp_q.push_back({last, en, 4'(sub), IDX_W'(elem)});
  endtask

  // Called at a falling edge in IDLE; returns at the falling edge after the start edge.
  task automatic issue_start(input int l, input int sew, input logic m);
    start      = 1'b1;
    vl         = 17'(l);
    vsew       = 3'(sew);
    instr_mask = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready follows 1,0,0,1 repeating.
  task automatic run_beats(input string tag, input int mode, output int cycles);
    logic [BW-1:0]       e;
    logic [IDX_W*NB-1:0] exp_idx;
    logic [3:0]          pat;
    int c;
    pat = 4'b1001;
    c = 0;
    while (exp_q.size() > 0 && c < 100) begin
      beat_ready = (mode == 1) ? pat[c % 4] : 1'b1;
      e = exp_q[0];
      for (int i = 0; i < NB; i++) exp_idx[i*IDX_W +: IDX_W] = e[IDX_W-1:0] + IDX_W'(i);
      chk({tag, "_valid"}, beat_valid, 1'b1);
      chk({tag, "_base"},  elem_base, e[IDX_W-1:0]);
      chk({tag, "_sub"},   sub_beat,  e[IDX_W+3:IDX_W]);
      chk({tag, "_en"},    lane_en,   e[IDX_W+4+NB-1:IDX_W+4]);
      chk({tag, "_last"},  last_beat, e[BW-1]);
      chk({tag, "_idx"},   lane_idx,  exp_idx);
      chk({tag, "_done0"}, done, 1'b0);
      if (beat_ready) void'(exp_q.pop_front());
      c++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s_timeout: observed %0d beats left expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    beat_ready = 1'b1;
    cycles = c;
  endtask

  // Called at the falling edge of the expected DONE cycle.
  task automatic check_done(input string tag);
    chk({tag, "_done"},   done, 1'b1);
    chk({tag, "_busyd"},  busy, 1'b1);
    chk({tag, "_validd"}, beat_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_done_end"}, done, 1'b0);
    chk({tag, "_idle"},     busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; vl = '0; vsew = '0;
    instr_mask = 1'b0; beat_ready = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", beat_valid, 1'b0);
    chk("rst_outs", {elem_base, lane_en, lane_idx, sub_beat, last_beat, done, err_illegal}, '0);
    chk("rst_state", dbg_state, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // vl=10, SEW=8: three beats, last one with only two live lanes.
    push_beat(0, 0, 4'b1111, 1'b0);
    push_beat(4, 0, 4'b1111, 1'b0);
    push_beat(8, 0, 4'b0011, 1'b1);
    issue_start(10, 0, 1'b0);
    chk("t1_busy", busy, 1'b1);
    run_beats("t1", 0, cyc);
    chk("t1_cycles", cyc, 3);
    check_done("t1");

    // SEW=32 on 8-bit lanes: 4 sub-beats of the same three elements.
    for (int s = 0; s < 4; s++) push_beat(0, s, 4'b0111, s == 3);
    issue_start(3, 2, 1'b0);
    run_beats("t2", 0, cyc);
    chk("t2_cycles", cyc, 4);
    check_done("t2");

    // Mask op: full register of 16 bytes regardless of vl; start in DONE is dropped.
    for (int b = 0; b < 4; b++) push_beat(b * 4, 0, 4'b1111, b == 3);
    issue_start(5, 0, 1'b1);
    run_beats("t3", 0, cyc);
    start = 1'b1;
    vl = 17'd8;
    vsew = 3'd0;
    instr_mask = 1'b0;
    chk("t3_done", done, 1'b1);
    @(negedge clk);
    start = 1'b0;
    chk("t3_start_in_done", busy, 1'b0);
    @(negedge clk);
    chk("t3_still_idle", busy, 1'b0);

    // Back-pressure: held beat stays put, 3 transfers over 5 cycles.
    push_beat(0, 0, 4'b1111, 1'b0);
    push_beat(4, 0, 4'b1111, 1'b0);
    push_beat(8, 0, 4'b0011, 1'b1);
    issue_start(10, 0, 1'b0);
    run_beats("t4", 1, cyc);
    chk("t4_cycles", cyc, 5);
    check_done("t4");

    // vl=0: straight to DONE, never valid.
    issue_start(0, 0, 1'b0);
    chk("t5_valid", beat_valid, 1'b0);
    check_done("t5");

    // Illegal SEW code.
    issue_start(8, 5, 1'b0);
    chk("t6_err", err_illegal, 1'b1);
    chk("t6_busy", busy, 1'b0);
    chk("t6_valid", beat_valid, 1'b0);
    @(negedge clk);
    chk("t6_err_end", err_illegal, 1'b0);
    chk("t6_busy2", busy, 1'b0);

    // Abort coinciding with the only (last) transfer.
    issue_start(4, 0, 1'b0);
    chk("t7_last", last_beat, 1'b1);
    chk("t7_en", lane_en, 4'b1111);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t7_done", done, 1'b0);
    chk("t7_busy", busy, 1'b0);
    chk("t7_state", dbg_state, 2'd0);
    @(negedge clk);
    chk("t7_done_late", done, 1'b0);

    // Abort in IDLE overrides start.
    abort = 1'b1;
    issue_start(4, 0, 1'b0);
    abort = 1'b0;
    chk("t8_busy", busy, 1'b0);
    chk("t8_err", err_illegal, 1'b0);

    // Async reset mid-RUN, then a normal run from element 0.
    beat_ready = 1'b0;
    issue_start(10, 0, 1'b0);
    chk("t9_valid", beat_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t9_rst_busy", busy, 1'b0);
    chk("t9_rst_valid", beat_valid, 1'b0);
    chk("t9_rst_outs", {elem_base, lane_en, lane_idx, sub_beat, last_beat, done}, '0);
    chk("t9_rst_state", dbg_state, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    beat_ready = 1'b1;
    @(negedge clk);
    chk("t9_no_done", done, 1'b0);
    push_beat(0, 0, 4'b1111, 1'b0);
    push_beat(4, 0, 4'b1111, 1'b0);
    push_beat(8, 0, 4'b0011, 1'b1);
    issue_start(10, 0, 1'b0);
    run_beats("t9", 0, cyc);
    chk("t9_cycles", cyc, 3);
    check_done("t9");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
